// File: rtl/spi_slave_if.sv
// SPI slave front end: oversamples the SPI pins on clk, deserializes MOSI into
// 32-bit frame words or 8-bit OOB bytes, and serializes reply data onto MISO.
module spi_slave_if #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] IDLE_WORD   = 32'h0000_0000,
    parameter logic [7:0]  IDLE_OOB    = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        spi_cs,
    input  logic        spi_frame,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_oob,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        underrun,
    output logic        frame_err
);

    // Handshake: rx_valid is a 1-cycle strobe with no back-pressure; tx_ready
    // pulses in the cycle tx_data is captured, and is only raised while tx_valid=1.

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] frame_sync;
    logic                   sclk_prev;
    logic [31:0]            rx_shift;
    logic [31:0]            tx_shift;
    logic [4:0]             bit_cnt;
    logic                   mode_oob;

    logic       sclk_s;
    logic       mosi_s;
    logic       cs_s;
    logic       frame_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [4:0] last_idx;

    assign sclk_s    = clk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign frame_s   = frame_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign last_idx  = mode_oob ? 5'd7 : 5'd31;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            frame_sync <= '1;
            sclk_prev  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            frame_sync <= {frame_sync[SYNC_STAGES-2:0], spi_frame};
            sclk_prev  <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spi_miso  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_oob    <= 1'b0;
            tx_ready  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            mode_oob  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_oob    <= 1'b0;
            tx_ready  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    bit_cnt  <= '0;
                    if (!cs_s) state <= LOAD;
                end
                LOAD: begin
                    bit_cnt <= '0;
                    if (cs_s) begin
                        spi_miso <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        mode_oob <= frame_s;
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            spi_miso <= tx_data[0];
                            tx_ready <= 1'b1;
                        end else begin
                            tx_shift <= frame_s ? {24'h0, IDLE_OOB} : IDLE_WORD;
                            spi_miso <= frame_s ? IDLE_OOB[0] : IDLE_WORD[0];
                            underrun <= 1'b1;
                        end
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        if (bit_cnt != 5'd0) frame_err <= 1'b1;
                        spi_miso <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= IDLE;
                    end else if (frame_s != mode_oob) begin
                        // Between units the loaded reply is kept; only the length changes.
                        if (bit_cnt != 5'd0) begin
                            frame_err <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= LOAD;
                        end else begin
                            mode_oob <= frame_s;
                        end
                    end else if (sclk_rise) begin
                        if (bit_cnt == last_idx) begin
                            rx_valid <= 1'b1;
                            rx_oob   <= mode_oob;
                            rx_data  <= mode_oob ? {24'h0, mosi_s, rx_shift[7:1]}
                                                 : {mosi_s, rx_shift[31:1]};
                            bit_cnt  <= '0;
                            state    <= LOAD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (mode_oob) rx_shift[7:0] <= {mosi_s, rx_shift[7:1]};
                            else          rx_shift      <= {mosi_s, rx_shift[31:1]};
                        end
                    end else if (sclk_fall && bit_cnt != 5'd0) begin
                        // The fall after a unit's last rise belongs to the next unit's bit 0.
                        tx_shift <= {1'b0, tx_shift[31:1]};
                        spi_miso <= tx_shift[1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a bit-banged SPI master plus pulse monitors,
// checked with immediate assertions against hand-computed values.
module tb_spi_slave_if;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_frame = 1'b1;
    logic [31:0] tx_data = 32'h0;
    logic        tx_valid = 1'b0;
    logic        spi_miso;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_oob;
    logic        tx_ready;
    logic        underrun;
    logic        frame_err;

    spi_slave_if dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs    (spi_cs),
        .spi_frame (spi_frame),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_oob    (rx_oob),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitors, sampled on the opposite edge
    int          n_tx_ready = 0;
    int          n_underrun = 0;
    int          n_frame_err = 0;
    logic [32:0] rx_log[$];
    int          rx_cyc_log[$];

    always @(negedge clk) begin
        if (tx_ready)  n_tx_ready++;
        if (underrun)  n_underrun++;
        if (frame_err) n_frame_err++;
        if (rx_valid) begin
            rx_log.push_back({rx_oob, rx_data});
            rx_cyc_log.push_back(cyc);
        end
    end

    // scoreboard
    logic [32:0] exp_q[$];
    int          rx_idx = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          last_rise = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [32:0] exp;
        logic [32:0] obs;
        exp = exp_q.pop_front();
        obs = (rx_idx < rx_log.size()) ? rx_log[rx_idx] : 'x;
        rx_idx++;
        check(tag, obs, exp);
    endtask

    // driver: one SPI unit, LSB first; master samples MISO on its rising edge
    task automatic spi_xfer(input logic [31:0] word, input int nbits,
                            input logic [31:0] nxt, input logic nxt_v,
                            output logic [31:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[i];
            repeat (HALF) @(negedge clk);
            spi_clk   = 1'b1;
            got[i]    = spi_miso;
            last_rise = cyc;
            if (i == 0) begin
                tx_data  = nxt;
                tx_valid = nxt_v;
            end
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] got;
        int b_txr;
        int b_und;
        int b_fe;
        int b_rx;

        // reset state
        wait_cyc(3);
        check("rst_miso", spi_miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_oob", rx_oob, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        wait_cyc(4);

        // OOB byte
        b_txr = n_tx_ready; b_und = n_underrun; b_fe = n_frame_err;
        spi_frame = 1'b1; tx_data = 32'h0000_003C; tx_valid = 1'b1;
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'h0000_00A5, 8, 32'h0, 1'b0, got);
        wait_cyc(HALF);
        exp_q.push_back({1'b1, 32'h0000_00A5});
        check_rx("oob_rx");
        check("oob_miso", got[7:0], 8'h3C);
        check("oob_latency", rx_cyc_log[rx_idx-1] - last_rise, 3);
        check("oob_tx_ready", n_tx_ready - b_txr, 1);
        check("oob_underrun", n_underrun - b_und, 1);
        spi_cs = 1'b1;
        wait_cyc(2*HALF);
        check("oob_frame_err", n_frame_err - b_fe, 0);
        check("idle_miso", spi_miso, 0);

        // two frame words
        b_txr = n_tx_ready; b_fe = n_frame_err;
        spi_frame = 1'b0;
        wait_cyc(HALF);
        tx_data = 32'hCAFE_F00D; tx_valid = 1'b1;
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'h1234_5678, 32, 32'h0BAD_C0DE, 1'b1, got);
        check("frm_miso0", got, 32'hCAFE_F00D);
        spi_xfer(32'hDEAD_BEEF, 32, 32'h0, 1'b0, got);
        check("frm_miso1", got, 32'h0BAD_C0DE);
        wait_cyc(HALF);
        exp_q.push_back({1'b0, 32'h1234_5678});
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        check_rx("frm_rx0");
        check_rx("frm_rx1");
        check("frm_tx_ready", n_tx_ready - b_txr, 2);
        spi_cs = 1'b1;
        wait_cyc(2*HALF);
        check("frm_frame_err", n_frame_err - b_fe, 0);

        // underrun on the first word
        b_und = n_underrun; b_txr = n_tx_ready;
        tx_valid = 1'b0;
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'h1357_9BDF, 32, 32'h7777_7777, 1'b1, got);
        check("und_miso", got, 32'h0000_0000);
        wait_cyc(HALF);
        exp_q.push_back({1'b0, 32'h1357_9BDF});
        check_rx("und_rx");
        check("und_pulses", n_underrun - b_und, 1);
        check("und_tx_ready", n_tx_ready - b_txr, 1);
        spi_cs = 1'b1; tx_valid = 1'b0;
        wait_cyc(2*HALF);

        // frame rises after 12 bits of a word
        b_fe = n_frame_err; b_rx = rx_log.size();
        spi_frame = 1'b0; tx_data = 32'h1111_2222; tx_valid = 1'b1;
        wait_cyc(HALF);
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'hFFFF_FFFF, 12, 32'h0000_00C3, 1'b1, got);
        wait_cyc(HALF);
        spi_frame = 1'b1;
        wait_cyc(HALF);
        check("abt_frame_err", n_frame_err - b_fe, 1);
        check("abt_no_rx", rx_log.size() - b_rx, 0);
        spi_xfer(32'h0000_005A, 8, 32'h0, 1'b0, got);
        wait_cyc(HALF);
        exp_q.push_back({1'b1, 32'h0000_005A});
        check_rx("abt_rx");
        check("abt_rx_count", rx_log.size() - b_rx, 1);
        check("abt_miso", got[7:0], 8'hC3);
        spi_cs = 1'b1;
        wait_cyc(2*HALF);

        // reset after 20 bits of a word
        spi_frame = 1'b0; tx_data = 32'hFFFF_FFFF; tx_valid = 1'b1;
        wait_cyc(HALF);
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'hAAAA_AAAA, 20, 32'hFFFF_FFFF, 1'b1, got);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_tx_ready", tx_ready, 0);
        spi_cs = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(HALF);
        b_rx = rx_log.size();
        tx_data = 32'h2468_ACE0; tx_valid = 1'b1;
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'hFFFF_0001, 32, 32'h0, 1'b1, got);
        wait_cyc(HALF);
        check("rst_rx_count", rx_log.size() - b_rx, 1);
        exp_q.push_back({1'b0, 32'hFFFF_0001});
        check_rx("rst_rx");
        check("rst_after_miso", got, 32'h2468_ACE0);
        spi_cs = 1'b1;
        wait_cyc(2*HALF);

        // OOB, frame word, OOB with silent mode switches in between
        b_fe = n_frame_err;
        spi_frame = 1'b1; tx_data = 32'h0000_00A7; tx_valid = 1'b1;
        wait_cyc(HALF);
        spi_cs = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'h0000_0011, 8, 32'h1234_5678, 1'b1, got);
        check("mix_miso0", got[7:0], 8'hA7);
        spi_frame = 1'b0;
        wait_cyc(HALF);
        spi_xfer(32'h8000_0001, 32, 32'h0000_006E, 1'b1, got);
        spi_frame = 1'b1;
        wait_cyc(HALF);
        spi_xfer(32'h0000_00FE, 8, 32'h0, 1'b0, got);
        check("mix_miso2", got[7:0], 8'h6E);
        wait_cyc(HALF);
        exp_q.push_back({1'b1, 32'h0000_0011});
        exp_q.push_back({1'b0, 32'h8000_0001});
        exp_q.push_back({1'b1, 32'h0000_00FE});
        check_rx("mix_rx0");
        check_rx("mix_rx1");
        check_rx("mix_rx2");
        check("mix_frame_err", n_frame_err - b_fe, 0);
        spi_cs = 1'b1;
        wait_cyc(2*HALF);
        check("end_rx_total", rx_log.size(), rx_idx);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
